bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits directly upstream of the per-digit BCD-to-7-segment decoders. Takes an unsigned binary value on a start strobe and produces DIGITS packed BCD nibbles. Each nibble drives one decoder instance. Handshake is start/busy/done; the result is held stable between conversions.

Parameters:
BIN_W, 14, width of binary input; legal range 4..32
DIGITS, 4, number of BCD output digits; legal range 1..9

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  conversion request; sampled only when busy=0
bin  input  BIN_W  unsigned binary value; sampled on the edge that accepts start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; result valid on bcd/overflow
bcd  output  4*DIGITS  packed BCD result; digit 0 (ones) in bits [3:0]
overflow  output  1  high when the last accepted bin >= 10^DIGITS

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift and BCD registers cleared. Reset overrides every other input, including mid-conversion; any conversion in progress is abandoned and no done pulse is produced.
- State machine: IDLE, SHIFT, DONE.
  - IDLE: start=1 latches bin into the shift register, clears the working BCD register, loads the bit counter with BIN_W, and moves to SHIFT. It also latches overflow_next = (bin >= 10^DIGITS), using a constant computed at elaboration.
  - SHIFT: busy=1. Each cycle, every working digit >= 5 first has 3 added (4-bit wrap). The concatenation {bcd_work, shift_reg} is then shifted left by 1. The counter decrements. When the counter reaches 1 on the current cycle, the next state is DONE.
  - DONE: lasts exactly one cycle. done=1, busy=0. bcd and overflow show the new result; both are updated on the edge that enters DONE. From DONE, start=1 is accepted exactly as in IDLE (back-to-back conversions). Otherwise the block returns to IDLE.
- Latency: with start sampled at edge N, busy is high from N+1 through N+BIN_W. done is high for the cycle following edge N+BIN_W. Throughput is one conversion per BIN_W+1 cycles.
- start while busy=1 is ignored and not queued. bin is don't-care except on the accepting edge.
- bcd and overflow hold their last values through IDLE and SHIFT; they change only when entering DONE or on reset.
- Overflow case: bcd holds the low DIGITS digits of the full decimal value. Higher digits are truncated, and overflow=1.
- Width rule: the internal working BCD register is exactly 4*DIGITS bits. Carries out of the top digit are discarded.
- Every nibble of bcd is always 0..9, as required by the downstream decoder.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN
- When defined:
  - Adds output port `blank`, width DIGITS, updated together with bcd.
  - blank[i]=1 when digit i and all higher digits are 0, for i >= 1. blank[0] is always 0, so a value of 0 shows a single "0".
  - Resets to all 0.
  - The top-level uses blank to force segment patterns off.
- When undefined: the port and its logic are absent; everything else is unchanged.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, bcd=16'h0000, overflow=0.
- start with bin=9999 at edge N -> busy high from edge N+1 through N+14; done high for exactly one cycle after edge N+14; bcd=16'h9999, overflow=0.
- bin=1234, then re-assert start in the DONE cycle with bin=0 -> first result 16'h1234; second done 15 cycles later with bcd=16'h0000; no idle gap needed.
- bin=42 accepted; then start pulsed with bin=77 at the 5th busy cycle -> the second start is ignored; result bcd=16'h0042; no extra done pulse.
- bin=16383 (BIN_W=14, DIGITS=4) -> overflow=1, bcd=16'h6383.
- rst asserted at the 7th busy cycle -> busy=0 next cycle, bcd=0, no done. A new start with bin=5 then gives bcd=16'h0005. With BIN2BCD_BLANK_EN defined and bin=5: blank=4'b1110; with bin=0: blank=4'b1110.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle for the sequential binary-to-BCD converter.
// The optional blanking output exists only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_if #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;

    modport master (output start, bin, input busy, done, bcd, overflow, blank);
    modport slave  (input start, bin, output busy, done, bcd, overflow, blank);
`else
    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Feeds the per-digit 7-segment decoders; result is held between conversions.
// Optional macro BIN2BCD_BLANK_EN adds a per-digit leading-zero blank output.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input logic          clk,
    input logic          rst,
    bin2bcd_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] OvfLimit = pow10(DIGITS);

`ifdef BIN2BCD_BLANK_EN
    // Digit i (i >= 1) blanks when it and every higher digit are zero.
    function automatic logic [DIGITS-1:0] calc_blank(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] b;
        logic              upper_zero;
        b          = '0;
        upper_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            upper_zero = upper_zero & (v[4*i +: 4] == 4'd0);
            b[i]       = upper_zero;
        end
        return b;
    endfunction
`endif

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    shift_q, shift_d;
    logic [4*DIGITS-1:0] work_q, work_d;
    logic [4*DIGITS-1:0] adj;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]   blank_q, blank_d;
`endif

    // Add-3 correction of every working digit that is 5 or more.
    always_comb begin
        adj = work_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (work_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic: accept, shift one bit per cycle, publish on entering DONE.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
`ifdef BIN2BCD_BLANK_EN
        blank_d    = blank_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    state_d    = StShift;
                    shift_d    = bus.bin;
                    work_d     = '0;
                    cnt_d      = CntW'(BIN_W);
                    ovf_pend_d = (64'(bus.bin) >= OvfLimit);
                end
            end
            StShift: begin
                // Top-digit carry falls off the end: low digits stay exact.
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                work_d  = {adj[4*DIGITS-2:0], shift_q[BIN_W-1]};
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    bcd_d   = work_d;
                    ovf_d   = ovf_pend_q;
`ifdef BIN2BCD_BLANK_EN
                    blank_d = calc_blank(work_d);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
`ifdef BIN2BCD_BLANK_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign bus.busy     = (state_q == StShift);
    assign bus.done     = (state_q == StDone);
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
`ifdef BIN2BCD_BLANK_EN
    assign bus.blank    = blank_q;
`endif

endmodule
